// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM widths, frame period, position type and scheduler states
package pwm_pkg;
    localparam int PWM_WIDTH  = 10;
    localparam int PWM_PERIOD = 1024;

    typedef logic [PWM_WIDTH-1:0] pos_t;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        SETTLE
    } state_t;
endpackage

// File: rtl/pwm_frame_timer.sv
// rtl/pwm_frame_timer.sv - free-running frame counter with a registered end-of-frame tick
module pwm_frame_timer import pwm_pkg::*; #(
    parameter int PERIOD = PWM_PERIOD
) (
    input  logic CLK,
    input  logic reset,
    output logic o_tick
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] r_count;
    logic          r_tick;
    logic [CW-1:0] w_next;

    assign w_next = (r_count == LAST) ? '0 : r_count + CW'(1);
    assign o_tick = r_tick;

    // Tick is registered from the next count so it is high exactly while the count sits at LAST.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_tick  <= (w_next == LAST);
        end
    end
endmodule

// File: rtl/pwm_ramp_scheduler.sv
// rtl/pwm_ramp_scheduler.sv - slews the PWM duty word toward accepted targets once per frame, then holds
module pwm_ramp_scheduler import pwm_pkg::*; #(
    parameter int WIDTH  = PWM_WIDTH,
    parameter int STEP_W = 4,
    parameter int HOLD_W = 8,
    parameter int PERIOD = PWM_PERIOD
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              i_tgt_valid,
    output logic              o_tgt_ready,
    input  logic [WIDTH-1:0]  i_tgt_pos,
    input  logic [STEP_W-1:0] i_step,
    input  logic [HOLD_W-1:0] i_hold_frames,
    output logic [WIDTH-1:0]  o_position,
    output logic              o_frame_tick,
    output logic              o_busy,
    output logic              o_done
);
    state_t              r_state;
    logic [WIDTH-1:0]    r_pos;
    logic [WIDTH-1:0]    r_tgt;
    logic [STEP_W-1:0]   r_step;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;

    logic                w_tick;
    logic                w_up;
    logic [WIDTH:0]      w_diff;
    logic [WIDTH:0]      w_step_ext;

    pwm_frame_timer #(.PERIOD(PERIOD)) u_timer (
        .CLK    (CLK),
        .reset  (reset),
        .o_tick (w_tick)
    );

    // Distance is taken one bit wider so the comparison against step never wraps.
    assign w_up       = (r_tgt > r_pos);
    assign w_diff     = w_up ? ({1'b0, r_tgt} - {1'b0, r_pos}) : ({1'b0, r_pos} - {1'b0, r_tgt});
    assign w_step_ext = (WIDTH+1)'(r_step);

    assign o_tgt_ready  = r_ready;
    assign o_position   = r_pos;
    assign o_frame_tick = w_tick;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_pos   <= '0;
            r_tgt   <= '0;
            r_step  <= '0;
            r_hold  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Ready re-arms one cycle after done so the two never overlap.
                    r_ready <= 1'b1;
                    if (i_tgt_valid && r_ready) begin
                        r_tgt   <= i_tgt_pos;
                        r_step  <= (i_step == '0) ? STEP_W'(1) : i_step;
                        r_hold  <= i_hold_frames;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= (i_tgt_pos == r_pos) ? SETTLE : RAMP;
                    end
                end
                RAMP: begin
                    if (w_tick) begin
                        if (w_diff <= w_step_ext) begin
                            r_pos   <= r_tgt;
                            r_state <= SETTLE;
                        end else if (w_up) begin
                            r_pos <= r_pos + WIDTH'(r_step);
                        end else begin
                            r_pos <= r_pos - WIDTH'(r_step);
                        end
                    end
                end
                SETTLE: begin
                    if ((r_hold == '0) || (w_tick && (r_hold == HOLD_W'(1)))) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_tick) begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// tb/tb_pwm_ramp_scheduler.sv - directed bench with a schedule-level reference model for pwm_ramp_scheduler
module tb_pwm_ramp_scheduler;
    localparam int P  = 16;
    localparam int W  = 10;
    localparam int SW = 4;
    localparam int HW = 8;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          tgt_valid = 1'b0;
    logic [W-1:0]  tgt_pos = '0;
    logic [SW-1:0] step = '0;
    logic [HW-1:0] hold = '0;
    logic          tgt_ready;
    logic [W-1:0]  position;
    logic          fr_tick;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    pwm_ramp_scheduler #(.WIDTH(W), .STEP_W(SW), .HOLD_W(HW), .PERIOD(P)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .i_tgt_valid   (tgt_valid),
        .o_tgt_ready   (tgt_ready),
        .i_tgt_pos     (tgt_pos),
        .i_step        (step),
        .i_hold_frames (hold),
        .o_position    (position),
        .o_frame_tick  (fr_tick),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: each accepted move is a record; outputs at any cycle follow from tick arithmetic.
    bit m_act = 0;
    int m_A, m_base, m_tgt, m_stp, m_k, m_t1, m_D;
    int m_last = 0;

    function automatic int next_tick_at(input int x);
        return x + (P - 1 - (x % P));
    endfunction

    function automatic int toward(input int p, input int t, input int s);
        int d;
        d = (t > p) ? t - p : p - t;
        if (d <= s) return t;
        return (t > p) ? p + s : p - s;
    endfunction

    function automatic int exp_pos(input int c);
        int n, p;
        if (!m_act) return m_last;
        n = (c - 1 >= m_t1) ? (c - 1 - m_t1) / P + 1 : 0;
        if (n > m_k) n = m_k;
        p = m_base;
        for (int i = 0; i < n; i++) p = toward(p, m_tgt, m_stp);
        return p;
    endfunction

    function automatic int exp_ready(input int c);
        return m_act ? int'(c > m_D) : 1;
    endfunction

    task automatic model_accept(input int c);
        int p, s_cyc, h;
        m_base = exp_pos(c);
        m_tgt  = int'(tgt_pos);
        m_stp  = (step == 0) ? 1 : int'(step);
        h      = int'(hold);
        m_A    = c;
        m_k    = 0;
        p      = m_base;
        while (p != m_tgt) begin
            p = toward(p, m_tgt, m_stp);
            m_k++;
        end
        m_t1  = next_tick_at(c + 1);
        s_cyc = (m_k == 0) ? c + 1 : m_t1 + P * (m_k - 1) + 1;
        m_D   = (h == 0) ? s_cyc + 1 : next_tick_at(s_cyc) + P * (h - 1) + 1;
        m_act = 1;
    endtask

    int c_now;
    always @(negedge CLK) begin
        if (reset) begin
            chk("rst_position", int'(position), 0);
            chk("rst_ready", int'(tgt_ready), 1);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_tick", int'(fr_tick), 0);
            m_act  = 0;
            m_last = 0;
        end else begin
            c_now = cyc;
            chk("position", int'(position), exp_pos(c_now));
            chk("tgt_ready", int'(tgt_ready), exp_ready(c_now));
            chk("busy", int'(busy), int'(m_act && c_now > m_A && c_now < m_D));
            chk("done", int'(done), int'(m_act && c_now == m_D));
            chk("frame_tick", int'(fr_tick), int'((c_now % P) == P - 1));
            if (tgt_valid && exp_ready(c_now) == 1) model_accept(c_now);
        end
    end

    task automatic step_cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic send(input int t, input int s, input int h);
        tgt_pos   = W'(t);
        step      = SW'(s);
        hold      = HW'(h);
        tgt_valid = 1'b1;
        step_cyc(1);
        tgt_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        @(negedge CLK);
        while (!done && n < limit) begin
            @(negedge CLK);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic next_tick_pos(output int p);
        int n;
        n = 0;
        @(negedge CLK);
        while (!fr_tick && n < 2 * P) begin
            @(negedge CLK);
            n++;
        end
        if (!fr_tick) chk("tick_timeout", 0, 1);
        @(negedge CLK);
        p = int'(position);
    endtask

    task automatic count_ticks(input int n, input string tag);
        int nt, first;
        nt = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (fr_tick) begin
                nt++;
                if (first < 0) first = cyc;
            end
        end
        chk({tag, "_tick_count"}, nt, n / P);
        chk({tag, "_first_tick"}, first, 15);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int n;
        #1 reset = 1'b1;
        repeat (3) @(posedge CLK);
        #2 reset = 1'b0;

        count_ticks(40, "reset_run");
        @(posedge CLK);
        #2;

        send(10, 4, 0);
        next_tick_pos(p); chk("up_step1", p, 4);
        next_tick_pos(p); chk("up_step2", p, 8);
        next_tick_pos(p); chk("up_final", p, 10);
        @(negedge CLK);
        chk("up_done_pulse", int'(done), 1);
        chk("up_busy_falls", int'(busy), 0);
        step_cyc(1);

        send(3, 3, 1);
        next_tick_pos(p); chk("down_step1", p, 7);
        next_tick_pos(p); chk("down_step2", p, 4);
        next_tick_pos(p); chk("down_final", p, 3);
        wait_done(2 * P);
        chk("down_hold_pos", int'(position), 3);
        step_cyc(1);

        send(1021, 15, 0);
        wait_done(80 * P);
        chk("climb_pos", int'(position), 1021);
        step_cyc(1);

        send(1023, 0, 0);
        next_tick_pos(p); chk("top_step1", p, 1022);
        next_tick_pos(p); chk("top_final", p, 1023);
        wait_done(2 * P);
        next_tick_pos(p); chk("top_no_wrap", p, 1023);
        step_cyc(1);

        send(5, 15, 0);
        wait_done(80 * P);
        chk("descend_pos", int'(position), 5);
        step_cyc(1);

        tgt_pos   = W'(5);
        step      = SW'(1);
        hold      = HW'(2);
        tgt_valid = 1'b1;
        step_cyc(1);
        tgt_pos = W'(9);
        wait_done(4 * P);
        tgt_valid = 1'b0;
        chk("settle_pos", int'(position), 5);
        step_cyc(2);
        chk("no_queued_accept", int'(busy), 0);

        n = 0;
        while ((cyc % P) != P - 1 && n < 2 * P) begin
            step_cyc(1);
            n++;
        end
        send(20, 3, 0);
        @(negedge CLK);
        chk("no_step_on_accept_tick", int'(position), 5);
        next_tick_pos(p); chk("first_step_next_tick", p, 8);
        step_cyc(1);
        reset = 1'b1;
        #1;
        chk("async_rst_pos", int'(position), 0);
        chk("async_rst_ready", int'(tgt_ready), 1);
        chk("async_rst_busy", int'(busy), 0);
        step_cyc(2);
        reset = 1'b0;
        count_ticks(20, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
